regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine for the 32×32-bit register file. On a start command it walks a register range through one register-file read port, one register per transfer. Each value leaves on a valid/ready stream tagged with its register index. It sits beside the datapath as the reader-side counterpart to the write-back path, and is used by the debug/trace logic to snapshot architectural state.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin a dump; sampled only in IDLE
- first_reg  in  ADDR_W  first index of range; latched on accepted start
- last_reg  in  ADDR_W  last index of range (inclusive); latched on accepted start
- ReadRegister  out  ADDR_W  address driven to register-file read port
- ReadData  in  DATA_W  combinational read data from register file for ReadRegister
- dump_valid  out  1  output word valid
- dump_ready  in  1  consumer accepts word when high with dump_valid
- dump_index  out  ADDR_W  register index of dump_data
- dump_data  out  DATA_W  register value (or checksum word)
- dump_last  out  1  marks final word of the dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after final word accepted

## Operation
- States: IDLE, READ, SEND, CKSUM (only with macro), DONE.
- IDLE: busy=0. start=1 latches first_reg/last_reg, ptr<=first_reg, clears checksum, goes to READ.
- READ: ReadRegister=ptr; ReadData captured into dump_data, dump_index<=ptr, dump_valid<=1; goes to SEND.
- SEND: dump_valid held, dump_data/dump_index/dump_last stable until dump_valid&&dump_ready.
  - On handshake with ptr!=last: ptr<=ptr+1 mod 32, dump_valid<=0, goes to READ.
  - On handshake with ptr==last: goes to CKSUM (macro on) or DONE.
- DONE: done=1 for exactly one cycle, busy=0, goes to IDLE.
- Range wrap: first_reg>last_reg walks up through 31, wraps to 0, stops at last_reg. first_reg==last_reg gives exactly one word.
- start while not IDLE: ignored; range inputs not re-latched.
- ReadRegister holds ptr in all non-IDLE states; holds 0 in IDLE.
- Register 0 is dumped like any other; it reads as whatever the file returns.
- No coherency with concurrent writes. Each value is the file contents during that register's READ cycle.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. ReadRegister, dump_index, dump_data, ptr, checksum = 0. dump_valid, dump_last, busy, done = 0.
- Reset mid-dump aborts immediately. No done pulse; the partial word is dropped.
- start accepted at edge t: READ during cycle t..t+1, busy=1 from t. Word valid from edge t+1.
- Per word: 1 READ cycle + ≥1 SEND cycle. Peak rate is one word per 2 cycles with dump_ready tied high.
- busy deasserts at the edge entering DONE. done is high the cycle after the final handshake.
- N-register dump, ready always high: final handshake at cycle t+2N, done pulse in the next cycle (macro off).

## Configuration
- REGFILE_DUMP_CKSUM_EN defined:
  - A running 32-bit sum, modulo 2^32, is kept of every register word emitted.
  - After the last register's handshake, CKSUM drives one extra word: dump_data=sum, dump_index=last_reg, dump_last=1.
  - dump_last is 0 on all register words.
  - DONE follows the checksum handshake; latency grows by 1 cycle plus ready stall.
- Undefined: no CKSUM state and no sum register. dump_last=1 on the last register word.

## Test plan
- Reset: hold rst=0 with start=1 → all outputs 0, busy=0; release → still IDLE until next start edge.
- Full dump: regs preloaded reg[i]=0x1000+i, first=0, last=31, ready=1 → 32 words, indices 0..31, data 0x1000..0x101F, dump_last on index 31, done at cycle t+65 (macro off).
- Backpressure: first=3, last=5, ready toggled 0,0,1 per word → each word holds data/index stable while stalled; exactly 3 words emitted.
- Wrap/single: first=30, last=1 → indices 30,31,0,1; first=7, last=7 → one word, index 7, dump_last=1.
- Abort: rst=0 during SEND of index 4 → dump_valid=0 same cycle, no done; a subsequent start runs cleanly.
- Checksum (REGFILE_DUMP_CKSUM_EN): regs 1..3 = 0xFFFFFFFF, 2, 3, range 1..3 → fourth word data 0x00000004, index 3, dump_last=1.

Source files
------------

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: valid/ready word stream carrying dumped register values.
// The master drives each word with its index; the slave returns dump_ready.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_index;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_index,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_index,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: walks a register range through one read port and streams each value.
// Define REGFILE_DUMP_CKSUM_EN to append a modulo-2^32 checksum word after the range.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ReadRegister,
  input  logic [DATA_W-1:0] ReadData,
  regfile_dump_if.master    dump,
  output logic              busy,
  output logic              done
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
`ifdef REGFILE_DUMP_CKSUM_EN
  localparam logic [2:0] CKSUM = 3'd3;
`endif
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] lastReg;
  logic [ADDR_W-1:0] indexReg;
  logic [DATA_W-1:0] dataReg;
  logic              validReg;
  logic              lastFlag;
  logic              busyReg;
  logic              doneReg;
`ifdef REGFILE_DUMP_CKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  logic handshake;
  logic atLast;

  assign handshake = validReg && dump.dump_ready;
  assign atLast    = (ptr == lastReg);

  assign ReadRegister    = (state == IDLE) ? '0 : ptr;
  assign dump.dump_valid = validReg;
  assign dump.dump_index = indexReg;
  assign dump.dump_data  = dataReg;
  assign dump.dump_last  = lastFlag;
  assign busy            = busyReg;
  assign done            = doneReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lastReg  <= '0;
      indexReg <= '0;
      dataReg  <= '0;
      validReg <= 1'b0;
      lastFlag <= 1'b0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
`ifdef REGFILE_DUMP_CKSUM_EN
      sum      <= '0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr     <= first_reg;
            lastReg <= last_reg;
            busyReg <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
            sum     <= '0;
`endif
            state   <= READ;
          end
        end

        READ: begin
          dataReg  <= ReadData;
          indexReg <= ptr;
          validReg <= 1'b1;
`ifdef REGFILE_DUMP_CKSUM_EN
          lastFlag <= 1'b0;
`else
          lastFlag <= atLast;
`endif
          state    <= SEND;
        end

        SEND: begin
          if (handshake) begin
`ifdef REGFILE_DUMP_CKSUM_EN
            sum <= sum + dataReg;
`endif
            if (!atLast) begin
              ptr      <= ptr + 1'b1;
              validReg <= 1'b0;
              state    <= READ;
            end else begin
`ifdef REGFILE_DUMP_CKSUM_EN
              // Checksum word includes the register word just accepted.
              dataReg  <= sum + dataReg;
              indexReg <= lastReg;
              lastFlag <= 1'b1;
              state    <= CKSUM;
`else
              validReg <= 1'b0;
              lastFlag <= 1'b0;
              busyReg  <= 1'b0;
              doneReg  <= 1'b1;
              state    <= DONE;
`endif
            end
          end
        end

`ifdef REGFILE_DUMP_CKSUM_EN
        CKSUM: begin
          if (handshake) begin
            validReg <= 1'b0;
            lastFlag <= 1'b0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b1;
            state    <= DONE;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          validReg <= 1'b0;
          lastFlag <= 1'b0;
          busyReg  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed and randomized dumps checked against a range/sum model
// of the register file; works with or without REGFILE_DUMP_CKSUM_EN.
module tb_regfile_dump;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGFILE_DUMP_CKSUM_EN
  localparam int CKSUM_ON = 1;
`else
  localparam int CKSUM_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] firstReg = '0;
  logic [ADDR_W-1:0] lastReg = '0;
  logic [ADDR_W-1:0] readReg;
  logic [DATA_W-1:0] readData;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] regs [0:31];
  int                checks = 0;
  int                errors = 0;

  regfile_dump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dumpBus ();

  regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .first_reg    (firstReg),
    .last_reg     (lastReg),
    .ReadRegister (readReg),
    .ReadData     (readData),
    .dump         (dumpBus.master),
    .busy         (busy),
    .done         (done)
  );

  assign readData = regs[readReg];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: ready 0,0,1 per word, 2: random ready
  task automatic run_dump(input int first, input int last, input int mode);
    int          n, nexp, k, j, waitCnt, idx;
    logic [31:0] sum;
    logic [4:0]  expIdx [0:32];
    logic [31:0] expData [0:32];
    logic        r;
    n   = ((last - first + 32) % 32) + 1;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      idx        = (first + i) % 32;
      expIdx[i]  = idx[4:0];
      expData[i] = regs[idx];
      sum        = sum + regs[idx];
    end
    nexp = n;
    if (CKSUM_ON != 0) begin
      expIdx[n]  = last[4:0];
      expData[n] = sum;
      nexp       = n + 1;
    end

    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 0);
    firstReg = first[4:0];
    lastReg  = last[4:0];
    start    = 1'b1;
    dumpBus.dump_ready = (mode == 0);
    @(negedge clk);
    start    = 1'b0;
    firstReg = 5'($urandom);
    lastReg  = 5'($urandom);
    check("start_busy", {31'd0, busy}, 1);
    check("start_valid", {31'd0, dumpBus.dump_valid}, 0);

    k = 0; j = 0; waitCnt = 0;
    while (k < nexp && j < 400) begin
      @(negedge clk);
      j++;
      check("rd_addr", {27'd0, readReg}, {27'd0, expIdx[k]});
      if (dumpBus.dump_valid) begin
        check("word_index", {27'd0, dumpBus.dump_index}, {27'd0, expIdx[k]});
        check("word_data", dumpBus.dump_data, expData[k]);
        check("word_last", {31'd0, dumpBus.dump_last}, (k == nexp - 1) ? 1 : 0);
        case (mode)
          0:       r = 1'b1;
          1:       r = (waitCnt == 2);
          default: r = 1'($urandom_range(0, 1));
        endcase
        dumpBus.dump_ready = r;
        waitCnt++;
        if (r) begin
          k++;
          waitCnt = 0;
        end
      end else begin
        dumpBus.dump_ready = (mode == 0);
      end
      // start while busy must be ignored
      start    = 1'($urandom_range(0, 1));
      firstReg = 5'($urandom);
      lastReg  = 5'($urandom);
    end
    check("word_count", k, nexp);
    start = 1'b0;

    @(negedge clk);
    j++;
    dumpBus.dump_ready = 1'b0;
    check("done_pulse", {31'd0, done}, 1);
    check("done_busy", {31'd0, busy}, 0);
    check("done_valid", {31'd0, dumpBus.dump_valid}, 0);
    if (mode == 0) check("done_cycle", j, 2 * n + CKSUM_ON);
    @(negedge clk);
    check("done_once", {31'd0, done}, 0);
    check("idle_addr", {27'd0, readReg}, 0);
    $display("dump first=%0d last=%0d mode=%0d words=%0d cycles=%0d", first, last, mode, k, j);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    dumpBus.dump_ready = 1'b0;

    // Reset held with start high
    rst = 1'b0; start = 1'b1; firstReg = 5'd3; lastReg = 5'd9;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, dumpBus.dump_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_last", {31'd0, dumpBus.dump_last}, 0);
    check("rst_data", dumpBus.dump_data, 0);
    check("rst_index", {27'd0, dumpBus.dump_index}, 0);
    check("rst_addr", {27'd0, readReg}, 0);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_valid", {31'd0, dumpBus.dump_valid}, 0);
    $display("reset checked");

    // Directed dumps
    run_dump(0, 31, 0);
    run_dump(3, 5, 1);
    run_dump(30, 1, 0);
    run_dump(7, 7, 0);

    // Abort during SEND of index 4
    @(negedge clk);
    firstReg = 5'd2; lastReg = 5'd10; start = 1'b1; dumpBus.dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(dumpBus.dump_valid && dumpBus.dump_index == 5'd4) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach", {27'd0, dumpBus.dump_index}, 4);
    rst = 1'b0;
    #1;
    check("abort_valid", {31'd0, dumpBus.dump_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_data", dumpBus.dump_data, 0);
    @(negedge clk);
    rst = 1'b1;
    dumpBus.dump_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 0);
    end
    $display("abort checked");
    run_dump(0, 5, 0);

    // Checksum overflow case
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd2; regs[3] = 32'd3;
    run_dump(1, 3, 0);

    // Randomized contents, ranges and backpressure
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
